uart_tx_param: RTL and testbench
================================

// Module: uart_tx_param
// PURPOSE
//  Parametrised UART transmitter: next generation of our fixed 8N1 transmitter.
//  Configurable data width, parity and stop bits; small input FIFO behind a valid/ready handshake.
//  Back-to-back frames with no idle gap.
//  Sits between a byte source (CPU/bridge) and the serial pin; bit timing comes from the shared baud tick generator.
// PARAMETERS
//  DATA_BITS   8  payload bits per frame, legal 5..9
//  PARITY_EN   0  1 = append parity bit after data
//  PARITY_ODD  0  1 = odd parity, 0 = even (ignored when PARITY_EN=0)
//  STOP_BITS   1  stop bits per frame, legal 1 or 2
//  FIFO_DEPTH  4  input buffer entries, power of 2, >=2
// PORTS
//  clk         in   1              system clock
//  rst         in   1              reset, synchronous, active-low
//  baud_tick   in   1              one-clk pulse per bit period
//  s_data      in   DATA_BITS      word to transmit
//  s_valid     in   1              s_data valid
//  s_ready     out  1              FIFO can accept (= !full)
//  tx          out  1              serial line, idle high
//  tx_busy     out  1              frame in progress (state != IDLE)
//  frame_done  out  1              one-clk pulse when the last stop bit completes
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
// BEHAVIOUR
//  Reset (rst==0 at posedge clk): tx=1, tx_busy=0, frame_done=0, s_ready=1, fifo_level=0.
//   FIFO emptied, state=IDLE. Applies mid-frame too: the line returns high the next cycle and the partial frame is abandoned.
//  Push: s_valid && s_ready at posedge -> write s_data. Push while full is ignored (s_ready=0).
//   Simultaneous push+pop when full: push still refused (s_ready is registered from level, no pass-through).
//   Push+pop otherwise: level unchanged.
//  Line timing: tx and state change only on clocks where baud_tick=1. All outputs registered.
//  Frame order: start(0), data LSB first, [parity], STOP_BITS x 1.
//  FSM states IDLE, START, DATA, PARITY, STOP:
//   IDLE : tx=1. On tick && !empty: pop into shift reg, tx<=0, ->START.
//   START: on tick: tx<=data[0], bit_cnt<=0, ->DATA.
//   DATA : on tick: if bit_cnt==DATA_BITS-1 -> PARITY (tx<=par) if PARITY_EN, else STOP (tx<=1, stop_cnt<=0).
//          else bit_cnt++, tx<=next bit.
//   PARITY: on tick: tx<=1, stop_cnt<=0, ->STOP.
//   STOP : on tick: if stop_cnt==STOP_BITS-1: frame_done<=1.
//          If !empty: pop, tx<=0, ->START (no idle gap). Else ->IDLE, tx stays 1.
//          Otherwise stop_cnt++.
//  par = ^data XOR PARITY_ODD, computed on the popped word.
//  Frame length = 1+DATA_BITS+PARITY_EN+STOP_BITS ticks. Latency push->start bit: <= 1 tick period + 2 clk when idle.
//  tx_busy=1 from the START-entry clock until IDLE is re-entered. Held 1 across back-to-back frames.
//  bit_cnt width $clog2(DATA_BITS); wraps never occur (explicit compare). FIFO pointers wrap mod FIFO_DEPTH.
//  s_valid with baud_tick absent: data buffers; nothing transmits until a tick.
// STRUCTURE
//  Package uart_pkg: tx state enum encoding, parity-mode constants, shared with the future uart_rx_param.
//  Sub-module uart_tx_fifo (sync FIFO, DATA_BITS x FIFO_DEPTH, full/empty/level). FSM and shifter stay in the top.
// TESTING (baud_tick every 4 clk unless stated)
//  8N1, push 0xA5 -> tx per tick 0,1,0,1,0,0,1,0,1,1; frame_done once, tx_busy low after.
//  8E1 and 8O1, push 0xA5 -> parity bit 0 (even) / 1 (odd) between data and stop; 7E2 push 0x7F -> parity 1, two stop ticks.
//  Push 0x11,0x22,0x33 back-to-back -> 30 contiguous bit periods, no idle tick, 3 frame_done pulses, tx_busy held.
//  FIFO_DEPTH=4, no ticks, push 6 words -> s_ready low after 4, level=4, words 5-6 dropped. Then ticks -> 4 frames only.
//  Push while full with pop same clk -> push refused, level 3 after.
//  rst low during data bit 3 -> next clk tx=1, tx_busy=0, level=0. Later push 0x5A -> clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: tx state encoding, parity-mode constants and parity helper.
// Also intended for the receive side.
package uart_pkg;

  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_MODE_EVEN = 1'b0;
  localparam logic PAR_MODE_ODD  = 1'b1;

  // Unused upper bits must be zero so they do not disturb the XOR reduction.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words for the UART transmitter.
// Ready and empty are registered from the next fill level.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_pop,
  output logic [DATA_BITS-1:0]          o_data,
  output logic                          o_ready,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic                 r_ready;
  logic                 r_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [LW-1:0]        w_level_nxt;

  assign w_push      = i_push && r_ready;
  assign w_pop       = i_pop && !r_empty;
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b1;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LW'(FIFO_DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the level.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_ready = r_ready;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-fed frame FSM with shifter, stepped by baud_tick.
// Frames run back-to-back while the FIFO holds data.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned BW       = $clog2(DATA_BITS);
  localparam logic        ODD_MODE = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

  tx_state_e            r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [BW-1:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic                 r_stop_cnt, w_stop_cnt_nxt;
  logic                 r_par, w_par_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_pop;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_fifo_data;

  uart_tx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (s_valid),
    .i_data  (s_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_ready (s_ready),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_par      <= w_par_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_par_nxt      = r_par;
    w_tx_nxt       = r_tx;
    w_done_nxt     = 1'b0;
    w_pop          = 1'b0;
    if (baud_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_tx_nxt    = 1'b0;
            w_state_nxt = ST_START;
          end
        end
        ST_START: begin
          w_tx_nxt      = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = ST_DATA;
        end
        ST_DATA: begin
          if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
            if (PARITY_EN != 0) begin
              w_tx_nxt    = r_par;
              w_state_nxt = ST_PARITY;
            end else begin
              w_tx_nxt       = 1'b1;
              w_stop_cnt_nxt = 1'b0;
              w_state_nxt    = ST_STOP;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
            w_tx_nxt      = r_shift[0];
            w_shift_nxt   = r_shift >> 1;
          end
        end
        ST_PARITY: begin
          w_tx_nxt       = 1'b1;
          w_stop_cnt_nxt = 1'b0;
          w_state_nxt    = ST_STOP;
        end
        ST_STOP: begin
          if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
            w_done_nxt = 1'b1;
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_tx_nxt    = 1'b0;
              w_state_nxt = ST_START;
            end else begin
              w_tx_nxt    = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_stop_cnt_nxt = 1'b1;
          end
        end
        default: begin
          w_tx_nxt    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
    // Popped word is latched with its parity so the next frame needs no further FIFO access.
    if (w_pop) begin
      w_shift_nxt = w_fifo_data;
      w_par_nxt   = parity_bit(MAX_DATA_BITS'(w_fifo_data), ODD_MODE);
    end
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign tx         = r_tx;
  assign tx_busy    = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Randomised and directed bench for uart_tx_param: four configurations (8N1, 8E1, 8O1, 7E2)
// share stimulus and are checked each cycle against a frame-level bit-list model.
module tb_uart_tx_param;

  localparam int NC    = 4;
  localparam int DEPTH = 4;
  localparam int LOGN  = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       valid;
  logic [8:0] data;

  logic       tx_w    [NC];
  logic       busy_w  [NC];
  logic       done_w  [NC];
  logic       ready_w [NC];
  logic [2:0] lvl_w   [NC];

  int checks = 0;
  int errors = 0;
  int phase  = 0;
  bit chk_en = 1'b0;

  // Model state per configuration
  logic [8:0] m_mem  [NC][DEPTH];
  int         m_cnt  [NC];
  int         m_rd   [NC];
  int         m_wr   [NC];
  logic       m_bits [NC][16];
  int         m_len  [NC];
  int         m_pos  [NC];
  bit         m_inf  [NC];
  logic       e_tx   [NC];
  logic       e_busy [NC];
  logic       e_done [NC];
  logic       e_ready[NC];
  int         e_lvl  [NC];

  // Tick-sampled log of DUT outputs, plus frame_done counts
  bit   rec = 1'b0;
  int   logn = 0;
  logic log_tx   [NC][LOGN];
  logic log_busy [NC][LOGN];
  int   done_cnt [NC];

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
    .clk(clk), .rst(rst), .baud_tick(tick), .s_data(data[7:0]), .s_valid(valid), .s_ready(ready_w[0]),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .frame_done(done_w[0]), .fifo_level(lvl_w[0]));
  uart_tx_param #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8e1 (
    .clk(clk), .rst(rst), .baud_tick(tick), .s_data(data[7:0]), .s_valid(valid), .s_ready(ready_w[1]),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .frame_done(done_w[1]), .fifo_level(lvl_w[1]));
  uart_tx_param #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8o1 (
    .clk(clk), .rst(rst), .baud_tick(tick), .s_data(data[7:0]), .s_valid(valid), .s_ready(ready_w[2]),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .frame_done(done_w[2]), .fifo_level(lvl_w[2]));
  uart_tx_param #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_7e2 (
    .clk(clk), .rst(rst), .baud_tick(tick), .s_data(data[6:0]), .s_valid(valid), .s_ready(ready_w[3]),
    .tx(tx_w[3]), .tx_busy(busy_w[3]), .frame_done(done_w[3]), .fifo_level(lvl_w[3]));

  function automatic int cfg_db(input int c);  return (c == 3) ? 7 : 8; endfunction
  function automatic bit cfg_pe(input int c);  return c != 0;           endfunction
  function automatic bit cfg_odd(input int c); return c == 2;           endfunction
  function automatic int cfg_sb(input int c);  return (c == 3) ? 2 : 1; endfunction

  function automatic void chk(input string name, input int c, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cfg%0d @%0t: got %0d expected %0d", name, c, $time, act, exp);
    end
  endfunction

  // Expected frame: start 0, data LSB first, optional parity, stop ones.
  task automatic build_frame(input int c, input logic [8:0] w);
    int n;
    bit p;
    p = cfg_odd(c);
    m_bits[c][0] = 1'b0;
    for (int i = 0; i < cfg_db(c); i++) begin
      m_bits[c][1+i] = w[i];
      p = p ^ w[i];
    end
    n = 1 + cfg_db(c);
    if (cfg_pe(c)) begin
      m_bits[c][n] = p;
      n++;
    end
    for (int s = 0; s < cfg_sb(c); s++) begin
      m_bits[c][n] = 1'b1;
      n++;
    end
    m_len[c] = n;
  endtask

  task automatic model_step(input bit r, input bit v, input bit t, input logic [8:0] d);
    bit push;
    logic [8:0] mask;
    for (int c = 0; c < NC; c++) begin
      if (!r) begin
        m_cnt[c] = 0; m_rd[c] = 0; m_wr[c] = 0; m_inf[c] = 1'b0;
        e_tx[c] = 1'b1; e_done[c] = 1'b0;
      end else begin
        push = v && (m_cnt[c] != DEPTH);
        e_done[c] = 1'b0;
        if (t) begin
          if (m_inf[c]) begin
            m_pos[c]++;
            if (m_pos[c] == m_len[c]) begin
              e_done[c] = 1'b1;
              m_inf[c]  = 1'b0;
            end
          end
          if (!m_inf[c] && m_cnt[c] > 0) begin
            build_frame(c, m_mem[c][m_rd[c]]);
            m_rd[c]  = (m_rd[c] + 1) % DEPTH;
            m_cnt[c] = m_cnt[c] - 1;
            m_inf[c] = 1'b1;
            m_pos[c] = 0;
          end
          e_tx[c] = m_inf[c] ? m_bits[c][m_pos[c]] : 1'b1;
        end
        if (push) begin
          mask = 9'((1 << cfg_db(c)) - 1);
          m_mem[c][m_wr[c]] = d & mask;
          m_wr[c]  = (m_wr[c] + 1) % DEPTH;
          m_cnt[c] = m_cnt[c] + 1;
        end
      end
      e_busy[c]  = m_inf[c];
      e_ready[c] = (m_cnt[c] != DEPTH);
      e_lvl[c]   = m_cnt[c];
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, log DUT state just after it.
  task automatic step(input bit r, input bit v, input logic [8:0] d, input bit t_en);
    bit t;
    t = t_en && (phase == 3);
    phase = (phase + 1) % 4;
    rst = r; valid = v; data = d; tick = t;
    @(posedge clk);
    model_step(r, v, t, d);
    #1;
    for (int c = 0; c < NC; c++) begin
      if (done_w[c]) done_cnt[c]++;
      if (rec && t && logn < LOGN) begin
        log_tx[c][logn]   = tx_w[c];
        log_busy[c][logn] = busy_w[c];
      end
    end
    if (rec && t && logn < LOGN) logn++;
  endtask

  task automatic clear_log();
    logn = 0;
    rec  = 1'b1;
    for (int c = 0; c < NC; c++) done_cnt[c] = 0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < 4 * n; i++) step(1'b1, 1'b0, 9'h000, 1'b1);
  endtask

  // First logged tick whose line level is the start bit.
  function automatic int start_idx(input int c);
    for (int i = 0; i < logn; i++) if (log_tx[c][i] == 1'b0) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NC; c++) begin
        chk("tx",         c, int'(tx_w[c]),    int'(e_tx[c]));
        chk("tx_busy",    c, int'(busy_w[c]),  int'(e_busy[c]));
        chk("frame_done", c, int'(done_w[c]),  int'(e_done[c]));
        chk("s_ready",    c, int'(ready_w[c]), int'(e_ready[c]));
        chk("fifo_level", c, int'(lvl_w[c]),   e_lvl[c]);
      end
    end
  end

  int exp_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int exp_5a [10] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1};

  initial begin
    int s;
    int run;
    bit found;
    rst = 1'b0; valid = 1'b0; data = '0; tick = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 9'h000, 1'b0);
    chk_en = 1'b1;
    chk("rst_tx",    0, int'(tx_w[0]),    1);
    chk("rst_busy",  0, int'(busy_w[0]),  0);
    chk("rst_ready", 0, int'(ready_w[0]), 1);
    chk("rst_level", 0, int'(lvl_w[0]),   0);

    // Single 0xA5 frame on every configuration
    clear_log();
    step(1'b1, 1'b1, 9'h0A5, 1'b1);
    run_ticks(14);
    s = start_idx(0);
    chk("a5_start_found", 0, int'(s >= 0), 1);
    if (s >= 0) begin
      for (int k = 0; k < 10; k++) chk("a5_8n1_bit", 0, int'(log_tx[0][s+k]), exp_a5[k]);
      chk("a5_8n1_idle_after", 0, int'(log_busy[0][s+10]), 0);
    end
    chk("a5_8n1_done_count", 0, done_cnt[0], 1);
    s = start_idx(1);
    if (s >= 0) chk("a5_8e1_parity", 1, int'(log_tx[1][s+9]), 0);
    s = start_idx(2);
    if (s >= 0) chk("a5_8o1_parity", 2, int'(log_tx[2][s+9]), 1);

    // 7E2 with 0x7F: seven ones give even-parity bit 1, then two stop bits
    clear_log();
    step(1'b1, 1'b1, 9'h07F, 1'b1);
    run_ticks(14);
    s = start_idx(3);
    chk("7f_start_found", 3, int'(s >= 0), 1);
    if (s >= 0) begin
      chk("7f_7e2_parity", 3, int'(log_tx[3][s+8]),   1);
      chk("7f_7e2_stop1",  3, int'(log_tx[3][s+9]),   1);
      chk("7f_7e2_stop2",  3, int'(log_busy[3][s+10]), 1);
      chk("7f_7e2_idle",   3, int'(log_busy[3][s+11]), 0);
    end

    // Back-to-back frames: 30 contiguous busy ticks on 8N1
    clear_log();
    step(1'b1, 1'b1, 9'h011, 1'b0);
    step(1'b1, 1'b1, 9'h022, 1'b0);
    step(1'b1, 1'b1, 9'h033, 1'b0);
    run_ticks(40);
    s = start_idx(0);
    run = 0;
    if (s >= 0) while (s + run < logn && log_busy[0][s+run]) run++;
    chk("b2b_busy_ticks", 0, run, 30);
    chk("b2b_done_count", 0, done_cnt[0], 3);
    if (s >= 0) begin
      chk("b2b_frame2_start", 0, int'(log_tx[0][s+10]), 0);
      chk("b2b_frame3_start", 0, int'(log_tx[0][s+20]), 0);
    end

    // Fill without ticks: words 5 and 6 dropped
    clear_log();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 9'(i + 1), 1'b0);
    step(1'b1, 1'b0, 9'h000, 1'b0);
    chk("full_level", 0, int'(lvl_w[0]),   4);
    chk("full_ready", 0, int'(ready_w[0]), 0);
    run_ticks(50);
    for (int c = 0; c < NC; c++) chk("full_frames", c, done_cnt[c], 4);

    // Push while full coinciding with a pop is refused
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 9'($urandom_range(0, 255)), 1'b0);
    chk("full2_level", 0, int'(lvl_w[0]), 4);
    while (phase != 3) step(1'b1, 1'b0, 9'h000, 1'b0);
    step(1'b1, 1'b1, 9'h099, 1'b1);
    chk("push_pop_full_level", 0, int'(lvl_w[0]), 3);
    run_ticks(50);

    // Random traffic with intermittent ticks
    for (int i = 0; i < 1500; i++)
      step(1'b1, 1'b1 && ($urandom_range(0, 9) < 3), 9'($urandom), ($urandom_range(0, 7) != 0));
    run_ticks(60);

    // Reset during data bit 3 of 8N1
    step(1'b1, 1'b1, 9'h05A, 1'b0);
    step(1'b1, 1'b1, 9'h0C3, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1, 1'b0, 9'h000, 1'b1);
      found = m_inf[0] && (m_pos[0] == 4);
    end
    chk("reach_data_bit3", 0, int'(found), 1);
    step(1'b0, 1'b0, 9'h000, 1'b1);
    chk("midrst_tx",    0, int'(tx_w[0]),   1);
    chk("midrst_busy",  0, int'(busy_w[0]), 0);
    chk("midrst_level", 0, int'(lvl_w[0]),  0);
    step(1'b1, 1'b0, 9'h000, 1'b1);
    clear_log();
    step(1'b1, 1'b1, 9'h05A, 1'b1);
    run_ticks(14);
    s = start_idx(0);
    chk("5a_start_found", 0, int'(s >= 0), 1);
    if (s >= 0) for (int k = 0; k < 10; k++) chk("5a_8n1_bit", 0, int'(log_tx[0][s+k]), exp_5a[k]);
    chk("5a_done_count", 0, done_cnt[0], 1);

    chk_en = 1'b0;
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
